regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: width of each register entry.
REQ-002 SHALL provide parameter ADDR_W, default 5: register address width, DEPTH = 2**ADDR_W entries.
REQ-003 SHALL provide parameter NUM_RD, default 2: number of independent asynchronous read ports (1..4).
REQ-004 SHALL provide port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port init_done  output  1  high when the clear sequence is complete and the file is usable.
REQ-007 SHALL provide port raddr  input  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-008 SHALL provide port rdata  output  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-009 SHALL provide port rbusy  output  NUM_RD  scoreboard busy bit of the entry addressed by each read port.
REQ-010 SHALL provide ports we0 (input, 1), waddr0 (input, ADDR_W) and wdata0 (input, DATA_W): write port 0.
REQ-011 SHALL provide ports we1 (input, 1), waddr1 (input, ADDR_W) and wdata1 (input, DATA_W): write port 1, which has priority over port 0.
REQ-012 SHALL provide port sb_set  input  1  marks entry sb_addr busy (a producer has been issued).
REQ-013 SHALL provide port sb_addr  input  ADDR_W  scoreboard set address.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR and READY.
REQ-015 In CLEAR, SHALL zero entry clr_cnt and clear its busy bit each cycle, then increment clr_cnt.
REQ-016 In CLEAR, when clr_cnt == DEPTH-1, SHALL transition to READY on the next edge; a full clear takes exactly DEPTH cycles.
REQ-017 SHALL hold init_done = 0 in CLEAR and 1 in READY.
REQ-018 In CLEAR, SHALL ignore we0, we1 and sb_set, and SHALL drive rdata = 0 and rbusy = 0.
REQ-019 In READY, rdata for port k SHALL combinationally return entry raddr[k], with zero latency.
REQ-020 An asserted weN SHALL write wdataN to entry waddrN at the clock edge, and SHALL clear that entry's busy bit.
REQ-021 When we0 and we1 target the same address in the same cycle, SHALL store wdata1.
REQ-022 Entry 0 SHALL always read 0: writes to it are discarded and its busy bit is never set.
REQ-023 sb_set SHALL set the busy bit of sb_addr at the clock edge.
REQ-024 When sb_set and a write hit the same address in the same cycle, the set SHALL win (busy = 1 after the edge), while the data is still written.
REQ-025 Writes to distinct addresses on both ports in the same cycle SHALL both take effect.

Reset
REQ-026 A reset sampled high SHALL force state = CLEAR, clr_cnt = 0 and init_done = 0 on that edge.
REQ-027 A reset asserted mid-CLEAR SHALL restart the sweep at entry 0.
REQ-028 A reset asserted in READY SHALL discard any same-cycle writes and sb_set.
REQ-029 After reset deasserts, init_done SHALL rise exactly DEPTH cycles later, with all entries and busy bits equal to 0.

Configuration
REQ-030 SHALL support the macro REGFILE_BYPASS_EN.
REQ-031 With REGFILE_BYPASS_EN defined, a read in READY whose address matches an active write SHALL return that write's data in the same cycle (we1 match before we0), and rbusy SHALL read 0 for that port unless sb_set targets the same address.
REQ-032 Without REGFILE_BYPASS_EN, SHALL omit forwarding logic: a same-cycle read returns the old value, the new value appears on the next cycle, and rbusy reflects the registered busy bit only.
REQ-033 Address 0 SHALL never be forwarded, in either configuration.

Verification
REQ-034 Reset test: pulse reset 1 cycle (DEPTH=32) -> init_done low for 32 cycles then high; all 32 addresses read 0 and rbusy = 0.
REQ-035 Reset-mid-clear test: reassert reset at clear cycle 10 -> init_done rises exactly 32 cycles after the second release.
REQ-036 Dual-write test: we0 writes addr 5 = 0x1111_1111 and we1 writes addr 5 = 0x2222_2222 -> addr 5 reads 0x2222_2222; a separate cycle writing addr 3 and addr 4 updates both.
REQ-037 Zero-entry test: write 0xDEAD_BEEF to addr 0 with sb_set on addr 0 -> rdata = 0 and rbusy = 0.
REQ-038 Scoreboard test: sb_set addr 7 -> rbusy = 1 for addr 7; then a write plus sb_set on addr 7 in the same cycle -> busy stays 1; a later write alone -> busy = 0.
REQ-039 Bypass test: read addr 9 while we0 writes 0xA5A5_A5A5 -> same-cycle rdata = 0xA5A5_A5A5 with REGFILE_BYPASS_EN, or the old value 0 without it; addr 9 reads 0xA5A5_A5A5 on the next cycle in both builds.

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with a per-entry scoreboard busy bit and a
// self-clearing sweep after reset. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       init_done,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic                       sb_set,
    input  logic [ADDR_W-1:0]          sb_addr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t               state;
    logic [ADDR_W-1:0]    clr_cnt;
    logic [DATA_W-1:0]    mem [DEPTH];
    logic [DEPTH-1:0]     busy;

    logic                 wr0_ok;
    logic                 wr1_ok;
    logic                 set_ok;

    // Entry 0 is hard-wired to zero, so its writes and scoreboard sets are dropped here.
    assign wr0_ok = we0 && (waddr0 != '0);
    assign wr1_ok = we1 && (waddr1 != '0);
    assign set_ok = sb_set && (sb_addr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST) begin
                        state     <= READY;
                        init_done <= 1'b1;
                    end
                end
                READY: begin
                    state     <= READY;
                    init_done <= 1'b1;
                end
                default: begin
                    state     <= CLEAR;
                    clr_cnt   <= '0;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

    // Port 1 is written last so it wins a same-address collision; a scoreboard set
    // is applied after both write-clears so a producer issue is never lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_cnt]  <= '0;
                busy[clr_cnt] <= 1'b0;
            end else begin
                if (wr0_ok) begin
                    mem[waddr0]  <= wdata0;
                    busy[waddr0] <= 1'b0;
                end
                if (wr1_ok) begin
                    mem[waddr1]  <= wdata1;
                    busy[waddr1] <= 1'b0;
                end
                if (set_ok) begin
                    busy[sb_addr] <= 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              rb;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = mem[ra];
            rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr1_ok && (waddr1 == ra)) begin
                rd = wdata1;
                rb = set_ok && (sb_addr == ra);
            end else if (wr0_ok && (waddr0 == ra)) begin
                rd = wdata0;
                rb = set_ok && (sb_addr == ra);
            end
`endif
        end

        assign rdata[k*DATA_W +: DATA_W] = (state == READY) ? rd : '0;
        assign rbusy[k]                  = (state == READY) && rb;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters); expectations
// follow REGFILE_BYPASS_EN when the bench is built with that macro.
module tb_regfile_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;

    logic                     clk;
    logic                     reset;
    logic                     init_done;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rbusy;
    logic                     we0;
    logic [ADDR_W-1:0]        waddr0;
    logic [DATA_W-1:0]        wdata0;
    logic                     we1;
    logic [ADDR_W-1:0]        waddr1;
    logic [DATA_W-1:0]        wdata1;
    logic                     sb_set;
    logic [ADDR_W-1:0]        sb_addr;

    int checks = 0;
    int errors = 0;

    regfile_sb #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NUM_RD(NUM_RD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .init_done(init_done),
        .raddr(raddr),
        .rdata(rdata),
        .rbusy(rbusy),
        .we0(we0),
        .waddr0(waddr0),
        .wdata0(wdata0),
        .we1(we1),
        .waddr1(waddr1),
        .wdata1(wdata1),
        .sb_set(sb_set),
        .sb_addr(sb_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle_inputs();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        sb_set = 1'b0; sb_addr = '0;
    endtask

    // Counts negedges after reset release until init_done rises (bounded).
    task automatic wait_init(output int cycles);
        cycles = 0;
        while (!init_done && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        int cycles;
        reset = 1'b1;
        idle_inputs();
        raddr = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_init_low: init_done=%b required 0", init_done);
        end
        reset = 1'b0;
        wait_init(cycles);
        checks++;
        if (cycles != DEPTH) begin
            errors++;
            $display("[TB] FAIL reset_latency: init_done after %0d cycles required %0d", cycles, DEPTH);
        end
        for (int a = 0; a < DEPTH; a++) begin
            raddr = {5'(DEPTH - 1 - a), 5'(a)};
            #1;
            checks++;
            if (rdata !== '0 || rbusy !== 2'b00) begin
                errors++;
                $display("[TB] FAIL reset_clear_addr%0d: rdata=%h rbusy=%b required 0/00", a, rdata, rbusy);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int cycles;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midclear_low: init_done=%b required 0", init_done);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_init(cycles);
        checks++;
        if (cycles != DEPTH) begin
            errors++;
            $display("[TB] FAIL midclear_latency: init_done after %0d cycles required %0d", cycles, DEPTH);
        end
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h1111_1111;
        we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h2222_2222;
        @(negedge clk);
        idle_inputs();
        raddr = {5'd0, 5'd5};
        #1;
        checks++;
        if (rdata[31:0] !== 32'h2222_2222) begin
            errors++;
            $display("[TB] FAIL dual_same_addr: rdata=%h required 22222222", rdata[31:0]);
        end
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h3333_0003;
        we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h4444_0004;
        @(negedge clk);
        idle_inputs();
        raddr = {5'd4, 5'd3};
        #1;
        checks++;
        if (rdata !== {32'h4444_0004, 32'h3333_0003}) begin
            errors++;
            $display("[TB] FAIL dual_distinct: rdata=%h required 4444000433330003", rdata);
        end
    endtask

    task automatic test_zero_entry();
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hDEAD_BEEF;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hDEAD_BEEF;
        sb_set = 1'b1; sb_addr = 5'd0;
        raddr = {5'd0, 5'd0};
        #1;
        checks++;
        if (rdata !== '0 || rbusy !== 2'b00) begin
            errors++;
            $display("[TB] FAIL zero_same_cycle: rdata=%h rbusy=%b required 0/00", rdata, rbusy);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rdata !== '0 || rbusy !== 2'b00) begin
            errors++;
            $display("[TB] FAIL zero_after: rdata=%h rbusy=%b required 0/00", rdata, rbusy);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        sb_set = 1'b1; sb_addr = 5'd7;
        @(negedge clk);
        idle_inputs();
        raddr = {5'd7, 5'd6};
        #1;
        checks++;
        if (rbusy !== 2'b10) begin
            errors++;
            $display("[TB] FAIL sb_set: rbusy=%b required 10", rbusy);
        end
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h7777_7777;
        sb_set = 1'b1; sb_addr = 5'd7;
        #1;
        checks++;
        if (rbusy[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sb_collide_same_cycle: rbusy[1]=%b required 1", rbusy[1]);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rbusy[1] !== 1'b1 || rdata[63:32] !== 32'h7777_7777) begin
            errors++;
            $display("[TB] FAIL sb_collide_after: rbusy[1]=%b rdata=%h required 1/77777777", rbusy[1], rdata[63:32]);
        end
        @(negedge clk);
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h7070_7070;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rbusy[1] !== 1'b0 || rdata[63:32] !== 32'h7070_7070) begin
            errors++;
            $display("[TB] FAIL sb_write_clears: rbusy[1]=%b rdata=%h required 0/70707070", rbusy[1], rdata[63:32]);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_data;
        logic        exp_busy;
`ifdef REGFILE_BYPASS_EN
        exp_data = 32'hA5A5_A5A5;
        exp_busy = 1'b0;
`else
        exp_data = 32'h0000_0000;
        exp_busy = 1'b1;
`endif
        @(negedge clk);
        sb_set = 1'b1; sb_addr = 5'd9;
        @(negedge clk);
        idle_inputs();
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hA5A5_A5A5;
        raddr = {5'd0, 5'd9};
        #1;
        checks++;
        if (rdata[31:0] !== exp_data || rbusy[0] !== exp_busy) begin
            errors++;
            $display("[TB] FAIL bypass_same_cycle: rdata=%h rbusy=%b required %h/%b", rdata[31:0], rbusy[0], exp_data, exp_busy);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rdata[31:0] !== 32'hA5A5_A5A5 || rbusy[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bypass_next_cycle: rdata=%h rbusy=%b required a5a5a5a5/0", rdata[31:0], rbusy[0]);
        end
    endtask

    task automatic test_reset_in_ready();
        int cycles;
        @(negedge clk);
        reset = 1'b1;
        we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h1234_5678;
        sb_set = 1'b1; sb_addr = 5'd11;
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        raddr = {5'd9, 5'd5};
        #1;
        checks++;
        if (init_done !== 1'b0 || rdata !== '0 || rbusy !== 2'b00) begin
            errors++;
            $display("[TB] FAIL ready_reset_clear_out: init_done=%b rdata=%h rbusy=%b required 0/0/00", init_done, rdata, rbusy);
        end
        wait_init(cycles);
        checks++;
        if (cycles != DEPTH) begin
            errors++;
            $display("[TB] FAIL ready_reset_latency: init_done after %0d cycles required %0d", cycles, DEPTH);
        end
        raddr = {5'd11, 5'd10};
        #1;
        checks++;
        if (rdata !== '0 || rbusy !== 2'b00) begin
            errors++;
            $display("[TB] FAIL ready_reset_discard: rdata=%h rbusy=%b required 0/00", rdata, rbusy);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_clear();
        test_dual_write();
        test_zero_entry();
        test_scoreboard();
        test_bypass();
        test_reset_in_ready();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
